aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath. Accepts a start request, steps the datapath through its initial AddRoundKey, the main rounds and the final round, and supplies the round number and key-expansion round constant each cycle. Holds the result until a downstream consumer takes it. Control only: block, key and state registers live in the datapath, which updates its state on `state_en`.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: total cipher rounds; legal range 2..14.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start_valid` in 1: request to encrypt; the block and key are present on datapath inputs.
- `start_ready` out 1: the controller can accept a request.
- `load_en` out 1: the datapath captures the input block and key at this edge.
- `update_type` out 3: 0 NO_UPDATE, 1 INIT_UPDATE, 2 MAIN_UPDATE, 3 FINAL_UPDATE.
- `round_no` out 4: current round, 0..NUM_ROUNDS.
- `rcon` out 8: round constant for this round's key expansion.
- `state_en` out 1: the datapath updates its state and round-key registers.
- `result_valid` out 1: the datapath result is final.
- `result_ready` in 1: the consumer accepts the result.
- `busy` out 1: the controller state is not IDLE.
- `abort` in 1: cancel the operation (see Configuration).
- `enc_count` out 16: number of completed encryptions; wraps modulo 2^16.

## Operation
States: IDLE, INIT, MAIN, FINAL, HOLD.

- **IDLE**
  - `start_ready` = 1.
  - Acceptance occurs when `start_valid` & `start_ready`. `load_en` = 1 in the same cycle (Mealy), and the next state is INIT.
- **INIT** (1 cycle)
  - `update_type` = 1, `round_no` = 0, `rcon` = 0x00, `state_en` = 1.
  - Next state is MAIN with `round_no` = 1.
- **MAIN**
  - `update_type` = 2, `state_en` = 1.
  - `round_no` increments each cycle.
  - When `round_no` = NUM_ROUNDS-1, the next state is FINAL.
- **FINAL** (1 cycle)
  - `update_type` = 3, `round_no` = NUM_ROUNDS, `state_en` = 1.
  - Next state is HOLD.
- **HOLD**
  - `result_valid` = 1, `update_type` = 0, `state_en` = 0, `round_no` holds at NUM_ROUNDS.
  - On `result_ready`, the next state is IDLE and `enc_count` increments.

`rcon` register:
- Loads 0x01 on entry to MAIN.
- Advances by GF(2^8) xtime (`{r[6:0],1'b0} ^ (8'h1b & {8{r[7]}})`) on each MAIN or FINAL advance.
- Output is 0x00 in IDLE, INIT and HOLD.
- Sequence for rounds 1..10: 01 02 04 08 10 20 40 80 1b 36. It continues with 6c d8 ab 4d for rounds above 10.

Other rules:
- `start_ready` = 0 in every state other than IDLE; requests arriving then are not accepted (no queuing).
- `busy` = (state != IDLE).

## Timing
- Acceptance at cycle T.
- INIT at T+1.
- MAIN at T+2..T+NUM_ROUNDS.
- FINAL at T+NUM_ROUNDS+1.
- `result_valid` is first high at T+NUM_ROUNDS+2. For the default, that is 12 cycles after acceptance.
- Back-to-back operation: the earliest next acceptance is the cycle after the HOLD handshake. Throughput is NUM_ROUNDS+3 cycles per block with `result_ready` tied high.
- While `reset` is high, at the next edge: state goes to IDLE; `round_no`, `rcon`, `update_type` and `enc_count` go to 0; `start_ready` = 0 combinationally (gated by `reset`); `load_en`, `state_en`, `result_valid` and `busy` = 0.
- Reset mid-operation: the next cycle is IDLE with no result and no count increment.
- `result_valid` stays high and `round_no` stays stable until the handshake; `result_ready` is ignored outside HOLD.
- `enc_count` wraps 0xFFFF to 0x0000.

## Configuration
Macro `AES_ROUND_CTRL_ABORT_EN`.

- **Defined:**
  - `abort` high at an edge forces IDLE at the next cycle from any state. No `result_valid` is produced and `enc_count` is not incremented.
  - In IDLE, `abort` blocks acceptance: `start_ready` = 0 and `load_en` = 0 while `abort` is high.
  - `abort` wins over `result_ready` in HOLD.
- **Undefined:** the `abort` port exists but is ignored; behaviour is identical to tying it low.

## Test plan
- **Single encryption.** Stimulus: pulse `start_valid` with `result_ready` = 1. Required: `load_en` at T; `update_type` sequence 1, 2×9, 3, 0; `round_no` 0..10; `rcon` 00, 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36; `result_valid` at T+12; `enc_count` = 1.
- **Backpressure.** Stimulus: `result_ready` = 0 for 5 cycles in HOLD, with `start_valid` held high. Required: `result_valid` stays 1, `start_ready` stays 0, no `load_en`; after the handshake, the next acceptance occurs 1 cycle later.
- **Reset mid-round.** Stimulus: assert `reset` for 1 cycle at `round_no` = 5. Required: the next cycle shows IDLE outputs, `rcon` = 0, `enc_count` = 0, `start_ready` = 1 once `reset` is low.
- **Abort (macro defined).** Stimulus: `abort` at `round_no` = 3. Required: IDLE the next cycle, no `result_valid`, `enc_count` unchanged. With `abort` and `start_valid` together in IDLE: no `load_en`. Macro undefined: `abort` has no effect.
- **Counter wrap.** Stimulus: preload 0xFFFF via 65535 runs (or force), then run one more. Required: `enc_count` = 0x0000.
- **Parameter.** Stimulus: NUM_ROUNDS = 14. Required: `result_valid` at T+16; `rcon` in round 14 = 0x4d.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 datapath: IDLE -> INIT -> MAIN* -> FINAL -> HOLD.
// Optional abort support is compiled in when AES_ROUND_CTRL_ABORT_EN is defined.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    output logic        load_en,
    output logic [2:0]  update_type,
    output logic [3:0]  round_no,
    output logic [7:0]  rcon,
    output logic        state_en,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy,
    input  logic        abort,
    output logic [15:0] enc_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MAIN  = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_MAIN  = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);
    localparam logic [7:0] RCON_POLY  = 8'h1b;

    state_t      state_reg, state_next;
    logic [3:0]  round_reg, round_next;
    logic [7:0]  rcon_reg, rcon_next;
    logic [7:0]  rcon_xtime;
    logic [15:0] enc_count_reg, enc_count_next;
    logic        abort_eff;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_eff = abort;
`else
    // Port kept for a uniform interface; it never influences the sequencer.
    assign abort_eff = abort & 1'b0;
`endif

    // GF(2^8) multiply-by-x of the running round constant.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_xtime
            if (gi == 0) begin : g_lsb
                assign rcon_xtime[gi] = RCON_POLY[gi] & rcon_reg[7];
            end else begin : g_upper
                assign rcon_xtime[gi] = rcon_reg[gi-1] ^ (RCON_POLY[gi] & rcon_reg[7]);
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        round_next     = round_reg;
        rcon_next      = rcon_reg;
        enc_count_next = enc_count_reg;
        start_ready    = 1'b0;
        load_en        = 1'b0;
        update_type    = 3'd0;
        state_en       = 1'b0;
        result_valid   = 1'b0;
        rcon           = 8'h00;

        case (state_reg)
            IDLE: begin
                start_ready = ~reset & ~abort_eff;
                if (start_valid && start_ready) begin
                    load_en    = 1'b1;
                    state_next = INIT;
                    round_next = 4'd0;
                end
            end
            INIT: begin
                update_type = 3'd1;
                state_en    = 1'b1;
                state_next  = MAIN;
                round_next  = 4'd1;
                rcon_next   = 8'h01;
            end
            MAIN: begin
                update_type = 3'd2;
                state_en    = 1'b1;
                rcon        = rcon_reg;
                round_next  = round_reg + 4'd1;
                rcon_next   = rcon_xtime;
                if (round_reg == LAST_MAIN) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                update_type = 3'd3;
                state_en    = 1'b1;
                rcon        = rcon_reg;
                rcon_next   = rcon_xtime;
                round_next  = ROUND_LAST;
                state_next  = HOLD;
            end
            HOLD: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next     = IDLE;
                    round_next     = 4'd0;
                    enc_count_next = enc_count_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything, including a HOLD handshake in the same cycle.
        if (abort_eff) begin
            state_next     = IDLE;
            round_next     = 4'd0;
            rcon_next      = 8'h00;
            enc_count_next = enc_count_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            round_reg     <= 4'd0;
            rcon_reg      <= 8'h00;
            enc_count_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            round_reg     <= round_next;
            rcon_reg      <= rcon_next;
            enc_count_reg <= enc_count_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign round_no  = round_reg;
    assign enc_count = enc_count_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed scoreboard bench for aes_round_ctrl: default 10-round instance plus a 14-round instance.
// Abort expectations follow AES_ROUND_CTRL_ABORT_EN.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_valid, result_ready, abort;
    logic        start_ready, load_en, state_en, result_valid, busy;
    logic [2:0]  update_type;
    logic [3:0]  round_no;
    logic [7:0]  rcon;
    logic [15:0] enc_count;

    logic        sv14, rr14, ab14;
    logic        start_ready14, load_en14, state_en14, result_valid14, busy14;
    logic [2:0]  update_type14;
    logic [3:0]  round_no14;
    logic [7:0]  rcon14;
    logic [15:0] enc_count14;

    aes_round_ctrl dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .load_en(load_en), .update_type(update_type), .round_no(round_no), .rcon(rcon),
        .state_en(state_en), .result_valid(result_valid), .result_ready(result_ready),
        .busy(busy), .abort(abort), .enc_count(enc_count)
    );

    aes_round_ctrl #(.NUM_ROUNDS(14)) dut14 (
        .clk(clk), .reset(reset), .start_valid(sv14), .start_ready(start_ready14),
        .load_en(load_en14), .update_type(update_type14), .round_no(round_no14), .rcon(rcon14),
        .state_en(state_en14), .result_valid(result_valid14), .result_ready(rr14),
        .busy(busy14), .abort(ab14), .enc_count(enc_count14)
    );

    typedef struct packed {
        logic [2:0] ut;
        logic [3:0] rn;
        logic [7:0] rc;
        logic       se;
        logic       rv;
    } exp_t;

    exp_t sb[$];
    logic [7:0] rcon_tab [1:14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                    8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};
    int checks = 0;
    int errors = 0;

    logic [16:0] obs10, obs14;
    assign obs10 = {update_type, round_no, rcon, state_en, result_valid};
    assign obs14 = {update_type14, round_no14, rcon14, state_en14, result_valid14};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic sv, input logic rr, input logic ab, input logic rst, input logic s14);
        @(negedge clk);
        start_valid  = sv;
        result_ready = rr;
        abort        = ab;
        reset        = rst;
        sv14         = s14;
        #1;
    endtask

    task automatic push_trace(input int n);
        sb.push_back('{3'd1, 4'd0, 8'h00, 1'b1, 1'b0});
        for (int r = 1; r < n; r++) sb.push_back('{3'd2, 4'(r), rcon_tab[r], 1'b1, 1'b0});
        sb.push_back('{3'd3, 4'(n), rcon_tab[n], 1'b1, 1'b0});
        sb.push_back('{3'd0, 4'(n), 8'h00, 1'b0, 1'b1});
    endtask

    task automatic pop_check(input string tag, input logic [16:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check(tag, 32'(obs), 32'(e));
        end
    endtask

    initial begin
        int first_rv;
        reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0; abort = 1'b0;
        sv14 = 1'b0; rr14 = 1'b1; ab14 = 1'b0;

        // Reset state
        step(1, 0, 0, 1, 0);
        check("rst_start_ready", 32'(start_ready), 32'd0);
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_outputs", 32'(obs10), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_busy14", 32'(busy14), 32'd0);
        step(0, 1, 0, 0, 0);
        check("idle_start_ready", 32'(start_ready), 32'd1);

        // Single encryption
        step(1, 1, 0, 0, 0);
        check("single_load_en", 32'(load_en), 32'd1);
        push_trace(10);
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("single_trace", obs10);
        end
        step(0, 1, 0, 0, 0);
        check("single_enc_count", 32'(enc_count), 32'd1);
        check("single_idle_busy", 32'(busy), 32'd0);
        $display("txn single: enc_count=%0d", enc_count);

        // Backpressure with start_valid held high
        step(1, 0, 0, 0, 0);
        check("bp_load_en", 32'(load_en), 32'd1);
        push_trace(10);
        for (int i = 1; i <= 11; i++) begin
            step(1, 0, 0, 0, 0);
            pop_check("bp_trace", obs10);
            check("bp_busy_no_load", 32'({start_ready, load_en}), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            if (i == 0) pop_check("bp_hold", obs10);
            check("bp_hold_valid", 32'(result_valid), 32'd1);
            check("bp_hold_no_accept", 32'({start_ready, load_en}), 32'd0);
            check("bp_hold_round", 32'(round_no), 32'd10);
        end
        step(1, 1, 0, 0, 0);
        check("bp_handshake_valid", 32'({result_valid, load_en}), 32'b10);
        step(1, 1, 0, 0, 0);
        check("bp_next_accept", 32'(load_en), 32'd1);
        check("bp_enc_count", 32'(enc_count), 32'd2);
        $display("txn backpressure: enc_count=%0d", enc_count);
        push_trace(10);

        // Reset during round 5
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("rstmid_trace", obs10);
        end
        step(0, 1, 0, 1, 0);
        pop_check("rstmid_round5", obs10);
        sb.delete();
        step(0, 1, 0, 0, 0);
        check("rstmid_idle_outputs", 32'(obs10), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_enc_count", 32'(enc_count), 32'd0);
        check("rstmid_start_ready", 32'(start_ready), 32'd1);
        $display("txn reset_mid: enc_count=%0d", enc_count);

        // Abort at round 3
        step(1, 1, 0, 0, 0);
        check("abort_load_en", 32'(load_en), 32'd1);
        push_trace(10);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("abort_trace", obs10);
        end
        step(0, 1, 1, 0, 0);
        pop_check("abort_round3", obs10);
`ifdef AES_ROUND_CTRL_ABORT_EN
        sb.delete();
        step(0, 1, 0, 0, 0);
        check("abort_idle_outputs", 32'(obs10), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0);
            check("abort_no_result", 32'(result_valid), 32'd0);
        end
        check("abort_enc_count", 32'(enc_count), 32'd0);
        step(1, 1, 1, 0, 0);
        check("abort_blocks_accept", 32'({start_ready, load_en}), 32'd0);
        step(0, 1, 0, 0, 0);
        check("abort_still_idle", 32'(busy), 32'd0);
`else
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("abort_ignored_trace", obs10);
        end
        step(0, 1, 0, 0, 0);
        check("abort_ignored_count", 32'(enc_count), 32'd1);
        step(1, 1, 1, 0, 0);
        check("abort_ignored_accept", 32'(load_en), 32'd1);
        push_trace(10);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("abort_ignored_trace2", obs10);
        end
        step(0, 1, 0, 0, 0);
        check("abort_ignored_count2", 32'(enc_count), 32'd2);
`endif
        $display("txn abort: enc_count=%0d", enc_count);

        // Counter wrap
        force dut.enc_count_reg = 16'hffff;
        step(0, 1, 0, 0, 0);
        release dut.enc_count_reg;
        check("wrap_preload", 32'(enc_count), 32'h0000ffff);
        step(1, 1, 0, 0, 0);
        check("wrap_load_en", 32'(load_en), 32'd1);
        push_trace(10);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("wrap_trace", obs10);
        end
        step(0, 1, 0, 0, 0);
        check("wrap_enc_count", 32'(enc_count), 32'd0);
        $display("txn wrap: enc_count=%0d", enc_count);

        // NUM_ROUNDS = 14
        step(0, 1, 0, 0, 1);
        check("r14_load_en", 32'(load_en14), 32'd1);
        push_trace(14);
        first_rv = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0, 0);
            pop_check("r14_trace", obs14);
            if (i == 15) check("r14_rcon_round14", 32'(rcon14), 32'h4d);
            if (result_valid14 && first_rv == 0) first_rv = i;
        end
        check("r14_result_latency", 32'(first_rv), 32'd16);
        step(0, 1, 0, 0, 0);
        check("r14_enc_count", 32'(enc_count14), 32'd1);
        $display("txn rounds14: latency=%0d enc_count=%0d", first_rv, enc_count14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
